// File: rtl/dmem_bridge.sv
// MEM-stage to req/ack data-bus bridge: stalls the core per access, returns load data, flags faults.
// Optional one-entry posted write buffer enabled by DMEM_BRIDGE_POSTED_WRITE_EN.
module dmem_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_write_en,
    input  logic              i_read_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_write_data,
    output logic [DATA_W-1:0] o_read_data,
    output logic              o_stall,
    output logic              o_fault,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata,
    input  logic              i_bus_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             posted;
    logic             access, aligned, single, can_post, timeout_hit;

    assign access      = i_read_en | i_write_en;
    assign aligned     = (i_addr[1:0] == 2'b00);
    assign single      = i_read_en ^ i_write_en;
    assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
    // In IDLE the buffer is always empty, so any aligned pure write can be posted.
    assign can_post = i_write_en & ~i_read_en & aligned;
`else
    assign can_post = 1'b0;
`endif

    always_comb begin
        o_stall = 1'b0;
        if (!rst) begin
            case (state)
                S_IDLE:  o_stall = access & ~can_post;
                // A draining posted write only holds the core if it presents a new access.
                S_BUS:   o_stall = posted ? access : 1'b1;
                default: o_stall = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            posted      <= 1'b0;
            o_read_data <= '0;
            o_fault     <= 1'b0;
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_wdata <= '0;
        end else begin
            o_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    wait_cnt <= '0;
                    if (access) begin
                        o_bus_we    <= i_write_en;
                        o_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                        o_bus_wdata <= i_write_data;
                        if (aligned && single) begin
                            o_bus_req <= 1'b1;
                            posted    <= can_post;
                            state     <= S_BUS;
                        end else begin
                            o_fault <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_BUS: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // Ack has priority over a timeout landing in the same cycle.
                    if (i_bus_ack || timeout_hit) begin
                        o_bus_req <= 1'b0;
                        posted    <= 1'b0;
                        state     <= posted ? S_IDLE : S_DONE;
                        if (!i_bus_ack || i_bus_err) begin
                            o_fault <= 1'b1;
                            if (!o_bus_we) o_read_data <= '0;
                        end else if (!o_bus_we) begin
                            o_read_data <= i_bus_rdata;
                        end
                    end
                end
                default: begin
                    wait_cnt <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_bridge.sv
// Scoreboard bench for dmem_bridge: transaction-level model pushes expected core responses and
// bus transfers; independent monitors pop and compare them.
module tb_dmem_bridge;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_write_en = 1'b0, i_read_en = 1'b0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [DATA_W-1:0] i_write_data = '0;
    logic [DATA_W-1:0] o_read_data;
    logic              o_stall, o_fault, o_bus_req, o_bus_we;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;
    logic              i_bus_ack = 1'b0;
    logic [DATA_W-1:0] i_bus_rdata = '0;
    logic              i_bus_err = 1'b0;

    dmem_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_write_en(i_write_en), .i_read_en(i_read_en),
        .i_addr(i_addr), .i_write_data(i_write_data),
        .o_read_data(o_read_data), .o_stall(o_stall), .o_fault(o_fault),
        .o_bus_req(o_bus_req), .o_bus_we(o_bus_we),
        .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
        .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata), .i_bus_err(i_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {int stall; bit fault; logic [31:0] rdata;} resp_t;
    typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; int cycles;} btx_t;
    typedef struct {int d; bit err; logic [31:0] rdata;} plan_t;

    resp_t       exp_q[$];
    btx_t        bus_q[$];
    plan_t       plan_q[$];
    int          errors = 0, checks = 0;
    logic [31:0] rd_model = '0;
    bit          mon_en = 0, resp_en = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus slave: acks in BUS cycle d of each transfer (d==0 means never).
    plan_t cur = '{0, 1'b0, 32'h0};
    int    rcnt = 0;
    always @(negedge clk) if (resp_en) begin
        if (o_bus_req) begin
            if (rcnt == 0) begin
                if (plan_q.size() > 0) cur = plan_q.pop_front();
                else cur = '{0, 1'b0, 32'h0};
            end
            rcnt++;
            i_bus_ack   = (rcnt == cur.d);
            i_bus_rdata = i_bus_ack ? cur.rdata : $urandom;
            i_bus_err   = i_bus_ack ? cur.err : 1'($urandom);
        end else begin
            rcnt        = 0;
            i_bus_ack   = 1'b0;
            i_bus_rdata = $urandom;
            i_bus_err   = 1'($urandom);
        end
    end

    // Core-side monitor: an access completes in the cycle it is presented with stall low.
    int scnt = 0;
    always @(negedge clk) if (mon_en) begin
        resp_t e;
        bit    done;
        done = 0;
        if (i_read_en | i_write_en) begin
            if (o_stall) scnt++;
            else begin
                done = 1;
                if (exp_q.size() == 0) check("unexpected_completion", 32'h1, 32'h0);
                else begin
                    e = exp_q.pop_front();
                    check("stall_cycles", 32'(scnt), 32'(e.stall));
                    check("fault", {31'h0, o_fault}, {31'h0, e.fault});
                    check("read_data", o_read_data, e.rdata);
                end
                scnt = 0;
            end
        end else check("idle_stall", {31'h0, o_stall}, 32'h0);
        if (!done) check("stray_fault", {31'h0, o_fault}, 32'h0);
    end

    // Bus-side monitor: fields must stay stable for the whole request.
    bit          req_prev = 0, unstable = 0;
    btx_t        got;
    always @(negedge clk) if (mon_en) begin
        btx_t e;
        if (o_bus_req) begin
            if (!req_prev) begin
                got.we = o_bus_we; got.addr = o_bus_addr; got.wdata = o_bus_wdata;
                got.cycles = 1; unstable = 0;
            end else begin
                got.cycles++;
                if (o_bus_we !== got.we || o_bus_addr !== got.addr || o_bus_wdata !== got.wdata)
                    unstable = 1;
            end
        end else if (req_prev) begin
            if (bus_q.size() == 0) check("unexpected_bus_txn", 32'h1, 32'h0);
            else begin
                e = bus_q.pop_front();
                check("bus_we", {31'h0, got.we}, {31'h0, e.we});
                check("bus_addr", got.addr, e.addr);
                check("bus_wdata", got.wdata, e.wdata);
                check("bus_cycles", 32'(got.cycles), 32'(e.cycles));
                check("bus_stable", {31'h0, unstable}, 32'h0);
            end
        end
        req_prev = o_bus_req;
    end

    // Reference model: computes the whole outcome of one access, then drives it.
    task automatic do_access(input bit re, input bit we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int d, input bit err,
                             input logic [31:0] rdata, input bit post, input int extra);
        resp_t r; btx_t b; plan_t p; int n; bit to, f; int k;
        if ((re && we) || addr[1:0] != 2'b00) begin
            r.stall = 1 + extra; r.fault = 1;
        end else begin
            to = (d == 0 || d > TO);
            n  = to ? TO : d;
            f  = to || err;
            b.we = we; b.addr = {addr[31:2], 2'b00}; b.wdata = wdata; b.cycles = n;
            bus_q.push_back(b);
            p.d = d; p.err = err; p.rdata = rdata;
            plan_q.push_back(p);
            if (post) begin r.stall = 0; r.fault = 0; end
            else begin r.stall = 1 + n + extra; r.fault = f; end
            if (re) rd_model = f ? 32'h0 : rdata;
        end
        r.rdata = rd_model;
        exp_q.push_back(r);
        i_read_en = re; i_write_en = we; i_addr = addr; i_write_data = wdata;
        for (k = 0; k < 40; k++) begin
            @(negedge clk);
            if (!o_stall) break;
        end
        if (k == 40) check("access_timeout", 32'h1, 32'h0);
        @(posedge clk); #1;
        i_read_en = 1'b0; i_write_en = 1'b0;
    endtask

    initial begin
        // Reset values, with a strobe present to confirm stall is held low.
        i_read_en = 1'b1; i_addr = 32'h10;
        #12;
        check("rst_stall", {31'h0, o_stall}, 32'h0);
        check("rst_bus_req", {31'h0, o_bus_req}, 32'h0);
        check("rst_bus_we", {31'h0, o_bus_we}, 32'h0);
        check("rst_bus_addr", o_bus_addr, 32'h0);
        check("rst_bus_wdata", o_bus_wdata, 32'h0);
        check("rst_read_data", o_read_data, 32'h0);
        check("rst_fault", {31'h0, o_fault}, 32'h0);
        i_read_en = 1'b0;
        @(negedge clk); rst = 1'b0;

        // Reset in the middle of a bus transfer, then a stray ack.
        @(posedge clk); #1; i_read_en = 1'b1; i_addr = 32'h40;
        @(posedge clk); #1;
        check("bus_req_before_rst", {31'h0, o_bus_req}, 32'h1);
        @(posedge clk); #2; rst = 1'b1; #1;
        check("midrst_bus_req", {31'h0, o_bus_req}, 32'h0);
        check("midrst_stall", {31'h0, o_stall}, 32'h0);
        i_read_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1; i_bus_ack = 1'b1; i_bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check("stray_ack_bus_req", {31'h0, o_bus_req}, 32'h0);
        check("stray_ack_stall", {31'h0, o_stall}, 32'h0);
        @(posedge clk); #1; i_bus_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_fault", {31'h0, o_fault}, 32'h0);
        check("stray_ack_read_data", o_read_data, 32'h0);
        @(posedge clk); #1;
        mon_en = 1; resp_en = 1;

        // Directed cases.
        do_access(1, 0, 32'h10, 32'h0, 1, 0, 32'hDEAD_BEEF, 0, 0);
        do_access(0, 1, 32'h20, 32'h1234_5678, TO, 0, 32'h0, 0, 0);
        do_access(0, 1, 32'h24, 32'hCAFE_0001, TO + 1, 0, 32'h0, 0, 0);
        do_access(1, 0, 32'h13, 32'h0, 1, 0, 32'h5555_5555, 0, 0);
        do_access(1, 0, 32'h30, 32'h0, 0, 0, 32'h0, 0, 0);
        do_access(1, 0, 32'h34, 32'h0, 2, 0, 32'h0BAD_F00D, 0, 0);
        do_access(1, 0, 32'h38, 32'h0, 3, 1, 32'h7777_7777, 0, 0);
        do_access(1, 1, 32'h40, 32'h1, 1, 0, 32'h0, 0, 0);
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
        do_access(0, 1, 32'h80, 32'hA5A5_A5A5, 3, 0, 32'h0, 1, 0);
        do_access(1, 0, 32'h80, 32'h0, 2, 0, 32'hA5A5_A5A5, 0, 3);
        do_access(0, 1, 32'h82, 32'h1, 1, 0, 32'h0, 0, 0);
`endif

        // Randomized accesses.
        for (int i = 0; i < 200; i++) begin
            int          kind, d;
            bit          re, we, err;
            logic [31:0] a;
            kind = int'($urandom_range(0, 9));
            a    = $urandom & 32'hFFFF_FFFC;
            re   = 1'($urandom); we = ~re;
            if (kind == 0) begin re = 1; we = 1; end
            else if (kind == 1) a[1:0] = 2'($urandom_range(1, 3));
`ifdef DMEM_BRIDGE_POSTED_WRITE_EN
            if (we && !re && a[1:0] == 2'b00) begin re = 1; we = 0; end
`endif
            d   = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 2));
            err = ($urandom_range(0, 4) == 0);
            do_access(re, we, a, $urandom, d, err, $urandom, 0, 0);
            if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
        end

        repeat (4) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("bus_q_drained", 32'(bus_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory bridge between the pipelined core's MEM-stage port and the external data bus. It converts the core's single-cycle read/write strobes into a registered req/ack bus transaction, stalls the core for the duration, and returns load data. It flags misaligned, errored and timed-out accesses. It sits directly downstream of the core's `o_data_mem_*` / `i_mem_read_data` port.

## Interface
Parameters:
- `ADDR_W`, 32, address width in bits.
- `DATA_W`, 32, data width in bits.
- `TIMEOUT`, 255, maximum cycles in BUS waiting for ack; minimum 1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `i_write_en` in 1: core store strobe.
- `i_read_en` in 1: core load strobe.
- `i_addr` in ADDR_W: byte address.
- `i_write_data` in DATA_W: store data.
- `o_read_data` out DATA_W: load result, registered.
- `o_stall` out 1: holds the core's MEM stage and everything upstream.
- `o_fault` out 1: one-cycle access-fault pulse.
- `o_bus_req` out 1: bus request, registered.
- `o_bus_we` out 1: 1 = write, 0 = read.
- `o_bus_addr` out ADDR_W: word-aligned bus address.
- `o_bus_wdata` out DATA_W: bus write data.
- `i_bus_ack` in 1: single-cycle transfer completion.
- `i_bus_rdata` in DATA_W: read data, valid with `i_bus_ack`.
- `i_bus_err` in 1: error qualifier, sampled only with `i_bus_ack`.

## Operation
The block has three states: IDLE, BUS and DONE.

IDLE:
- An access is present when `i_read_en | i_write_en`.
- `o_stall` is combinationally 1 while an access is present.
- At the clock edge the block latches address, data and direction.
- Aligned access (`i_addr[1:0]==0`) with exactly one strobe: next state BUS, `o_bus_req`=1.
- Misaligned access, or both strobes high: no bus transaction, `o_fault`=1 for one cycle, next state DONE.

BUS:
- `o_stall`=1.
- `o_bus_req`, `o_bus_we`, `o_bus_addr` and `o_bus_wdata` are held stable until ack.
- The wait counter increments each cycle.
- On `i_bus_ack`:
  - `o_bus_req` drops at that edge.
  - For a read, `o_read_data` <= `i_bus_rdata`.
  - If `i_bus_err`=1: `o_fault` pulses and `o_read_data` <= 0.
  - Next state DONE.
- Counter reaching `TIMEOUT` without ack: drop req, `o_fault` pulse, `o_read_data` <= 0, next state DONE.

DONE:
- `o_stall`=0, so the core advances at this edge.
- Strobes are ignored in this state.
- Next state IDLE; the counter clears.

Other rules:
- `o_read_data` holds its value until the next completed read.
- Writes never modify `o_read_data`.
- `o_bus_addr` is driven with `i_addr[ADDR_W-1:2]`, 2'b00.

## Timing
- Reset values: state IDLE, `o_read_data`=0, `o_fault`=0, `o_bus_req`=0, `o_bus_we`=0, `o_bus_addr`=0, `o_bus_wdata`=0, counter 0.
- `o_stall`=0 in reset.
- Reset asserted mid-transaction: `o_bus_req` drops immediately (asynchronously) and the transaction is abandoned. A late ack after reset release is ignored in IDLE.
- Minimum access, with ack in the first BUS cycle:
  - Cycle 0: IDLE, `o_stall`=1.
  - Cycle 1: BUS, req=1, ack=1, `o_stall`=1.
  - Cycle 2: DONE, `o_stall`=0, data valid.
  - The core therefore stalls for 2 cycles.
- Ack in BUS cycle k adds k-1 stall cycles to the minimum.
- Fault path: IDLE → DONE, 1 stall cycle; `o_fault` is high during the DONE cycle.
- Ack and timeout in the same cycle: the ack wins and no timeout fault is raised.

## Configuration
- `DMEM_BRIDGE_POSTED_WRITE_EN` defined: adds a one-entry posted write buffer.
  - An aligned write accepted in IDLE with the buffer empty is captured with `o_stall`=0, so the core does not stall.
  - The block enters BUS with a posted flag set; on ack it returns directly to IDLE, skipping DONE.
  - Any access presented while a posted write is draining sees `o_stall`=1 until the drain completes. It is then processed normally from IDLE.
  - A posted write that errors or times out pulses `o_fault` at completion.
  - Misaligned writes are never posted.
- Macro undefined: every write follows the standard stalled path.

## Test plan
- Aligned read of 0x0000_0010, bus acks in the first BUS cycle with rdata 0xDEAD_BEEF → `o_stall` high for 2 cycles, then `o_read_data`=0xDEAD_BEEF, `o_fault`=0.
- Aligned write of 0x1234_5678 to 0x0000_0020, ack delayed 5 cycles → req, addr and wdata stable for 5 cycles, `o_bus_we`=1, 6 stall cycles, `o_read_data` unchanged.
- Read of 0x0000_0013 (misaligned) → no `o_bus_req`, `o_fault` high in the cycle after the stall, 1 stall cycle.
- Read with `TIMEOUT`=4 and no ack → req drops after 4 BUS cycles, `o_fault`=1, `o_read_data`=0; ack with `i_bus_err`=1 gives the same fault result.
- `rst` asserted during BUS → `o_bus_req`=0 in the same cycle; after release the block is in IDLE and ignores a stray ack.
- With the macro defined: write then read back-to-back → write shows no stall; read stalls until the write ack, then completes normally with the correct data.
